sata_oob_ctrl: RTL and testbench



---
 rtl/sata_oob_pkg.sv | 23 ++
 rtl/sata_oob_timer.sv | 43 ++++
 rtl/sata_oob_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_sata_oob_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sata_oob_pkg.sv
// Shared types and helpers for the SATA host OOB sequencer and its burst coder.
package sata_oob_pkg;

    typedef enum logic [3:0] {
        ST_RESET        = 4'd0,
        ST_RESET_BUSY   = 4'd1,
        ST_WAIT_COMINIT = 4'd2,
        ST_WAKE         = 4'd3,
        ST_WAKE_BUSY    = 4'd4,
        ST_WAIT_COMWAKE = 4'd5,
        ST_WAIT_ALIGN   = 4'd6,
        ST_SEND_ALIGN   = 4'd7,
        ST_LINKUP       = 4'd8
    } sata_oob_ctrl_state_t;

    localparam int NONALIGN_CNT = 3;

    // Cycle count for a duration in microseconds at a clock given in kHz, rounded to nearest.
    function automatic int khz_us_to_cycles(input int khz, input int us);
        return (khz * us + 32'sd500) / 32'sd1000;
    endfunction

endpackage

// File: rtl/sata_oob_timer.sv
// Saturating up-counter with synchronous clear, count enable and terminal-count compare.
module sata_oob_timer
    import sata_oob_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, then enabled increment that holds at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/sata_oob_ctrl.sv
// Host-side SATA OOB link-initialisation sequencer (COMRESET, COMWAKE, ALIGN exchange).
// Optional retry counter output enabled by defining SATA_OOB_RETRY_CNT_EN.
module sata_oob_ctrl
    import sata_oob_pkg::*;
#(
    parameter int CLKFREQ    = 100_000,
    parameter int TIMEOUT_US = 880,
    parameter int ALIGN_WAIT = 54600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coder_ready,
    output logic       cominit,
    output logic       comwake,
    output logic       oobfinish,
    input  logic       rx_cominit,
    input  logic       rx_comwake,
    input  logic       rx_align,
    output logic       tx_align,
    output logic       linkup
`ifdef SATA_OOB_RETRY_CNT_EN
    ,
    output logic [7:0] retry_cnt
`endif
);

    localparam int TMO = khz_us_to_cycles(CLKFREQ, TIMEOUT_US);
    localparam int TW  = $clog2(((TMO > ALIGN_WAIT) ? TMO : ALIGN_WAIT) + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TMO - 1);
    localparam logic [TW-1:0] ALIGN_LAST = TW'(ALIGN_WAIT - 1);
    localparam logic [1:0]    NAL_LAST   = 2'(NONALIGN_CNT - 1);

    sata_oob_ctrl_state_t state_q, state_d;
    logic          seen_low_q, seen_low_d;
    logic [1:0]    nal_q, nal_d;
    logic          cominit_q, cominit_d;
    logic          comwake_q, comwake_d;
    logic          oobfinish_q, oobfinish_d;
    logic          tx_align_q, tx_align_d;
    logic          linkup_q, linkup_d;
    logic          timeout_s;
    logic          in_wait_s;
    logic          timer_clr_s;
    logic          timer_tc_s;
    logic [TW-1:0] tc_val_s;

    sata_oob_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (timer_clr_s),
        .en     (in_wait_s),
        .tc_val (tc_val_s),
        .tc     (timer_tc_s)
    );

    // Sequencer next-state, command pulses and timeout detection.
    always_comb begin
        state_d    = state_q;
        seen_low_d = seen_low_q;
        nal_d      = nal_q;
        cominit_d  = 1'b0;
        comwake_d  = 1'b0;
        timeout_s  = 1'b0;
        in_wait_s  = 1'b0;
        tc_val_s   = TMO_LAST;
        case (state_q)
            ST_RESET: begin
                if (coder_ready) begin
                    cominit_d = 1'b1;
                    state_d   = ST_RESET_BUSY;
                end else begin
                    state_d = ST_RESET;
                end
            end
            ST_RESET_BUSY, ST_WAKE_BUSY: begin
                // The coder must be seen busy before its return to ready ends the train.
                if (!coder_ready) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    state_d = (state_q == ST_RESET_BUSY) ? ST_WAIT_COMINIT : ST_WAIT_COMWAKE;
                end else begin
                    seen_low_d = seen_low_q;
                end
            end
            ST_WAIT_COMINIT: begin
                in_wait_s = 1'b1;
                if (rx_cominit) begin
                    state_d = ST_WAKE;
                end else if (timer_tc_s) begin
                    state_d   = ST_RESET;
                    timeout_s = 1'b1;
                end else begin
                    state_d = ST_WAIT_COMINIT;
                end
            end
            ST_WAKE: begin
                if (coder_ready) begin
                    comwake_d = 1'b1;
                    state_d   = ST_WAKE_BUSY;
                end else begin
                    state_d = ST_WAKE;
                end
            end
            ST_WAIT_COMWAKE: begin
                in_wait_s = 1'b1;
                if (rx_cominit) begin
                    state_d = ST_RESET;
                end else if (rx_comwake) begin
                    state_d = ST_WAIT_ALIGN;
                end else if (timer_tc_s) begin
                    state_d   = ST_RESET;
                    timeout_s = 1'b1;
                end else begin
                    state_d = ST_WAIT_COMWAKE;
                end
            end
            ST_WAIT_ALIGN: begin
                in_wait_s = 1'b1;
                tc_val_s  = ALIGN_LAST;
                if (rx_cominit) begin
                    state_d = ST_RESET;
                end else if (rx_align) begin
                    state_d = ST_SEND_ALIGN;
                end else if (timer_tc_s) begin
                    state_d   = ST_RESET;
                    timeout_s = 1'b1;
                end else begin
                    state_d = ST_WAIT_ALIGN;
                end
            end
            ST_SEND_ALIGN: begin
                if (rx_cominit) begin
                    state_d = ST_RESET;
                end else if (rx_align) begin
                    nal_d = 2'd0;
                end else if (nal_q == NAL_LAST) begin
                    state_d = ST_LINKUP;
                end else begin
                    nal_d = nal_q + 2'd1;
                end
            end
            ST_LINKUP: begin
                if (rx_cominit) begin
                    state_d = ST_RESET;
                end else begin
                    state_d = ST_LINKUP;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
        timer_clr_s = (state_d != state_q);
        if (timer_clr_s) begin
            seen_low_d = 1'b0;
            nal_d      = 2'd0;
        end else begin
            seen_low_d = seen_low_d;
        end
        oobfinish_d = (state_d == ST_WAIT_ALIGN) || (state_d == ST_SEND_ALIGN) ||
                      (state_d == ST_LINKUP);
        tx_align_d  = (state_d == ST_SEND_ALIGN);
        linkup_d    = (state_d == ST_LINKUP);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RESET;
            seen_low_q  <= 1'b0;
            nal_q       <= 2'd0;
            cominit_q   <= 1'b0;
            comwake_q   <= 1'b0;
            oobfinish_q <= 1'b0;
            tx_align_q  <= 1'b0;
            linkup_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            seen_low_q  <= seen_low_d;
            nal_q       <= nal_d;
            cominit_q   <= cominit_d;
            comwake_q   <= comwake_d;
            oobfinish_q <= oobfinish_d;
            tx_align_q  <= tx_align_d;
            linkup_q    <= linkup_d;
        end
    end

    assign cominit   = cominit_q;
    assign comwake   = comwake_q;
    assign oobfinish = oobfinish_q;
    assign tx_align  = tx_align_q;
    assign linkup    = linkup_q;

`ifdef SATA_OOB_RETRY_CNT_EN
    logic [7:0] retry_q, retry_d;

    // Saturating count of timeout retries, cleared once the link comes up.
    always_comb begin
        retry_d = retry_q;
        if ((state_d == ST_LINKUP) && (state_q != ST_LINKUP)) begin
            retry_d = 8'd0;
        end else if (timeout_s && (retry_q != 8'hFF)) begin
            retry_d = retry_q + 8'd1;
        end else begin
            retry_d = retry_q;
        end
    end

    // Retry counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            retry_q <= 8'd0;
        end else begin
            retry_q <= retry_d;
        end
    end

    assign retry_cnt = retry_q;
`endif

endmodule

// File: tb/tb_sata_oob_ctrl.sv
// Self-checking bench for sata_oob_ctrl: scenario table, hand sequences and randomized runs vs a phase model.
module tb_sata_oob_ctrl;
    import sata_oob_pkg::*;

    localparam int TMO        = 50;
    localparam int ALIGN_WAIT = 40;

    localparam int P_RESET = 0, P_RBUSY = 1, P_WCI = 2, P_WAKE = 3, P_WBUSY = 4;
    localparam int P_WCW = 5, P_WAL = 6, P_SEND = 7, P_LINK = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic coder_ready = 1'b0;
    logic rx_cominit = 1'b0;
    logic rx_comwake = 1'b0;
    logic rx_align = 1'b0;
    logic cominit, comwake, oobfinish, tx_align, linkup;
`ifdef SATA_OOB_RETRY_CNT_EN
    logic [7:0] retry_cnt;
`endif

    always #5 clk = ~clk;

    sata_oob_ctrl #(.CLKFREQ(1000), .TIMEOUT_US(50), .ALIGN_WAIT(ALIGN_WAIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .coder_ready (coder_ready),
        .cominit     (cominit),
        .comwake     (comwake),
        .oobfinish   (oobfinish),
        .rx_cominit  (rx_cominit),
        .rx_comwake  (rx_comwake),
        .rx_align    (rx_align),
        .tx_align    (tx_align),
        .linkup      (linkup)
`ifdef SATA_OOB_RETRY_CNT_EN
        ,
        .retry_cnt   (retry_cnt)
`endif
    );

    typedef struct {
        int          busy;
        int          ci;
        int          cw;
        logic [15:0] pat;
        bit          hold;
        int          cycles;
        bit          exp_link;
        int          exp_ci;
        int          exp_cw;
    } scn_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: link phase, time spent in it, and expected output levels.
    int m_phase = P_RESET, m_age = 0, m_quiet = 0, m_retry = 0;
    bit m_low = 0, m_ci = 0, m_cw = 0, m_oob = 0, m_tx = 0, m_link = 0;

    // Environment: coder busy model and scripted device.
    int busy_len = 10, busy_left = 0, last_cmd = 0;
    int ci_delay = -1, cw_delay = -1, ci_cnt = 0, cw_cnt = 0;
    int cnt_ci = 0, cnt_cw = 0;
    bit hold_low = 0, ret_pending = 0, ci_armed = 0, cw_armed = 0, prev_oob = 0, spur = 0;
    logic [15:0] sc_pat = 16'h0000;
    logic [15:0] al_pat = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rdy, input logic rci, input logic rcw,
                              input logic ral, input logic rst);
        int nxt;
        bit to;
        m_ci = 0;
        m_cw = 0;
        to   = 0;
        if (rst) begin
            m_phase = P_RESET; m_age = 0; m_low = 0; m_quiet = 0; m_retry = 0;
            m_oob = 0; m_tx = 0; m_link = 0;
            return;
        end
        nxt = m_phase;
        case (m_phase)
            P_RESET: if (rdy) begin m_ci = 1; nxt = P_RBUSY; end
            P_RBUSY, P_WBUSY: begin
                if (!rdy) m_low = 1;
                else if (m_low) nxt = (m_phase == P_RBUSY) ? P_WCI : P_WCW;
            end
            P_WCI: begin
                if (rci) nxt = P_WAKE;
                else if (m_age + 1 == TMO) begin nxt = P_RESET; to = 1; end
            end
            P_WAKE: if (rdy) begin m_cw = 1; nxt = P_WBUSY; end
            P_WCW: begin
                if (rci) nxt = P_RESET;
                else if (rcw) nxt = P_WAL;
                else if (m_age + 1 == TMO) begin nxt = P_RESET; to = 1; end
            end
            P_WAL: begin
                if (rci) nxt = P_RESET;
                else if (ral) nxt = P_SEND;
                else if (m_age + 1 == ALIGN_WAIT) begin nxt = P_RESET; to = 1; end
            end
            P_SEND: begin
                if (rci) nxt = P_RESET;
                else begin
                    m_quiet = ral ? 0 : m_quiet + 1;
                    if (m_quiet == NONALIGN_CNT) nxt = P_LINK;
                end
            end
            P_LINK: if (rci) nxt = P_RESET;
            default: nxt = P_RESET;
        endcase
        if (nxt != m_phase) begin
            m_age = 0; m_low = 0; m_quiet = 0;
        end else begin
            m_age++;
        end
        if (to && m_retry < 255) m_retry++;
        if (nxt == P_LINK && m_phase != P_LINK) m_retry = 0;
        m_phase = nxt;
        m_oob   = (nxt >= P_WAL);
        m_tx    = (nxt == P_SEND);
        m_link  = (nxt == P_LINK);
    endtask

    task automatic env_update();
        bit ret_event;
        ret_event = 0;
        if (cominit === 1'b1) begin busy_left = busy_len; last_cmd = 1; end
        if (comwake === 1'b1) begin busy_left = busy_len; last_cmd = 2; end
        if (busy_left > 0) begin
            coder_ready = 1'b0;
            busy_left--;
            ret_pending = 1;
        end else begin
            coder_ready = !hold_low;
            if (ret_pending && !hold_low) begin ret_event = 1; ret_pending = 0; end
        end
        rx_cominit = 1'b0;
        if (ret_event && last_cmd == 1 && ci_delay >= 0) begin ci_armed = 1; ci_cnt = ci_delay; end
        else if (ci_armed) ci_cnt--;
        if (ci_armed && ci_cnt == 0) begin rx_cominit = 1'b1; ci_armed = 0; end
        rx_comwake = 1'b0;
        if (ret_event && last_cmd == 2 && cw_delay >= 0) begin cw_armed = 1; cw_cnt = cw_delay; end
        else if (cw_armed) cw_cnt--;
        if (cw_armed && cw_cnt == 0) begin rx_comwake = 1'b1; cw_armed = 0; end
        if (oobfinish === 1'b1 && !prev_oob) al_pat = sc_pat;
        prev_oob = (oobfinish === 1'b1);
        rx_align = al_pat[0];
        al_pat   = al_pat >> 1;
        if (spur) begin
            if ($urandom_range(0, 99) == 0) rx_cominit = 1'b1;
            if ($urandom_range(0, 49) == 0) rx_comwake = 1'b1;
            if ($urandom_range(0, 19) == 0) rx_align = ~rx_align;
            reset = ($urandom_range(0, 799) == 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(coder_ready, rx_cominit, rx_comwake, rx_align, reset);
        #1;
        chk("cominit", cominit, m_ci);
        chk("comwake", comwake, m_cw);
        chk("oobfinish", oobfinish, m_oob);
        chk("tx_align", tx_align, m_tx);
        chk("linkup", linkup, m_link);
`ifdef SATA_OOB_RETRY_CNT_EN
        chk("retry_cnt", retry_cnt, m_retry);
`endif
        if (cominit === 1'b1) cnt_ci++;
        if (comwake === 1'b1) cnt_cw++;
        env_update();
    endtask

    task automatic start_scn(input scn_t s);
        busy_len = s.busy; ci_delay = s.ci; cw_delay = s.cw; sc_pat = s.pat; hold_low = s.hold;
        busy_left = 0; ret_pending = 0; ci_armed = 0; cw_armed = 0; al_pat = 16'h0000;
        prev_oob = 0; last_cmd = 0;
        reset = 1'b1;
        coder_ready = !s.hold;
        rx_cominit = 1'b0; rx_comwake = 1'b0; rx_align = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        cnt_ci = 0;
        cnt_cw = 0;
    endtask

    scn_t tbl[8];
    scn_t hs;

    initial begin
        //         busy ci   cw   pat       hold cyc  link ci cw
        tbl[0] = '{10,  20,  15,  16'h001F, 0,   300, 1,   1, 1};
        tbl[1] = '{10,  -1,  -1,  16'h0000, 0,   300, 0,   5, 0};
        tbl[2] = '{10,  20,  50,  16'h001F, 0,   300, 1,   1, 1};
        tbl[3] = '{10,  20,  51,  16'h001F, 0,   250, 0,   3, 3};
        tbl[4] = '{10,  50,  15,  16'h001F, 0,   300, 1,   1, 1};
        tbl[5] = '{10,  51,  15,  16'h001F, 0,   300, 0,   5, 0};
        tbl[6] = '{10,  20,  15,  16'h001F, 1,   100, 0,   0, 0};
        tbl[7] = '{10,  20,  15,  16'h0000, 0,   250, 0,   3, 3};

        for (int i = 0; i < 8; i++) begin
            start_scn(tbl[i]);
            chk("reset_state", {cominit, comwake, oobfinish, tx_align, linkup}, 32'd0);
            repeat (tbl[i].cycles) tick();
            chk($sformatf("scn%0d_linkup", i), linkup, tbl[i].exp_link);
            chk($sformatf("scn%0d_cominit_pulses", i), cnt_ci, tbl[i].exp_ci);
            chk($sformatf("scn%0d_comwake_pulses", i), cnt_cw, tbl[i].exp_cw);
        end

        // ALIGN count restarted by an interleaved ALIGN, short coder trains.
        hs = '{3, 5, 7, 16'h0013, 0, 200, 1, 1, 1};
        start_scn(hs);
        repeat (hs.cycles) tick();
        chk("interleaved_linkup", linkup, 1);

        // Device-initiated reset from link-up.
        rx_cominit = 1'b1;
        tick();
        chk("drop_linkup", linkup, 0);
        chk("drop_oobfinish", oobfinish, 0);
        cnt_ci = 0;
        for (int k = 0; k < 20 && cnt_ci == 0; k++) tick();
        chk("recominit", cnt_ci, 1);

        // Reset while sending ALIGN.
        hs = '{10, 20, 15, 16'hFFFF, 0, 0, 1, 1, 1};
        start_scn(hs);
        for (int k = 0; k < 300 && tx_align !== 1'b1; k++) tick();
        chk("reach_send_align", tx_align, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_outputs", {cominit, comwake, oobfinish, tx_align, linkup}, 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_RESET));

        // Randomized runs with spurious device events and occasional resets.
        for (int r = 0; r < 10; r++) begin
            hs.busy   = int'($urandom_range(1, 15));
            hs.ci     = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 60));
            hs.cw     = int'($urandom_range(0, 60));
            hs.pat    = 16'($urandom);
            hs.hold   = 0;
            start_scn(hs);
            spur = 1;
            repeat (400) tick();
            spur = 0;
            reset = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
